// File: rtl/dadd_sink_buf_if.sv
// Beat bus for dadd_sink_buf: the dadd result input plus the valid/ready forward port.
// The slave modport is the buffer's view and the master modport is the producer/consumer side.
interface dadd_sink_buf_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          dadd_out_en;
    logic [AW-1:0] dadd_out_addr;
    logic [DW-1:0] dadd_out;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;

    modport slave (
        input  dadd_out_en, dadd_out_addr, dadd_out, fwd_ready,
        output fwd_valid, fwd_addr, fwd_data
    );

    modport master (
        output dadd_out_en, dadd_out_addr, dadd_out, fwd_ready,
        input  fwd_valid, fwd_addr, fwd_data
    );
endinterface

// File: rtl/dadd_sink_buf.sv
// FWFT receive buffer decoupling the non-stallable dadd output from a back-pressuring consumer.
// Optional macro DADD_SINK_BUF_DROP_CNT_EN adds a saturating 16-bit drop counter output.
module dadd_sink_buf #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dadd_sink_buf_if.slave         bus,
    input  logic                   ovf_clr,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic                   buf_full,
    output logic                   ovf_flag
`ifdef DADD_SINK_BUF_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          push;
    logic          pop;
    logic          drop;

    assign buf_full      = (buf_count == CW'(DEPTH));
    assign bus.fwd_valid = (buf_count != '0);
    assign bus.fwd_addr  = mem[rp][EW-1:DW];
    assign bus.fwd_data  = mem[rp][DW-1:0];

    // A full buffer still accepts a beat when the head leaves in the same cycle.
    assign pop  = bus.fwd_valid && bus.fwd_ready;
    assign push = bus.dadd_out_en && (!buf_full || pop);
    assign drop = bus.dadd_out_en && buf_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp <= '0;
        end else if (push) begin
            mem[wp] <= {bus.dadd_out_addr, bus.dadd_out};
            wp      <= wp + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp        <= '0;
            buf_count <= '0;
        end else begin
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 1'b1;
                2'b01:   buf_count <= buf_count - 1'b1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end
    end

`ifdef DADD_SINK_BUF_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dadd_sink_buf.sv
// Scoreboard bench for dadd_sink_buf: a reference occupancy/flag model plus a queue of expected beats.
module tb_dadd_sink_buf;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic        clk;
    logic        rst_n;
    logic        ovf_clr;
    logic [3:0]  buf_count;
    logic        buf_full;
    logic        ovf_flag;
`ifdef DADD_SINK_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    dadd_sink_buf_if #(.DW(DW), .AW(AW)) bus ();

    dadd_sink_buf #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .ovf_clr   (ovf_clr),
        .buf_count (buf_count),
        .buf_full  (buf_full),
        .ovf_flag  (ovf_flag)
`ifdef DADD_SINK_BUF_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nTests  = 0;
    int          nFailed = 0;
    int          nPopped = 0;
    logic [63:0] expQ[$];
    int          mCount = 0;
    logic        mOvf   = 1'b0;
    logic [15:0] mDrop  = '0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle, checks the state left by the previous edge, then advances the model.
    task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic [31:0] data,
                                 input logic ready, input logic clr);
        logic        mPop;
        logic        mPush;
        logic        mDropNow;
        logic [63:0] beat;
        @(negedge clk);
        bus.dadd_out_en   = en;
        bus.dadd_out_addr = addr;
        bus.dadd_out      = data;
        bus.fwd_ready     = ready;
        ovf_clr           = clr;
        #1;
        checkOutput("fwd_valid", 64'(bus.fwd_valid), 64'(mCount != 0));
        checkOutput("buf_count", 64'(buf_count), 64'(mCount));
        checkOutput("buf_full", 64'(buf_full), 64'(mCount == DEPTH));
        checkOutput("ovf_flag", 64'(ovf_flag), 64'(mOvf));
`ifdef DADD_SINK_BUF_DROP_CNT_EN
        checkOutput("drop_cnt", 64'(drop_cnt), 64'(mDrop));
`endif
        mPop     = (mCount != 0) && ready;
        mPush    = en && ((mCount < DEPTH) || mPop);
        mDropNow = en && (mCount == DEPTH) && !mPop;
        if (mPop) begin
            beat = expQ.pop_front();
            checkOutput("fwd_beat", {bus.fwd_addr, bus.fwd_data}, beat);
            nPopped++;
        end
        if (mPush) expQ.push_back({addr, data});
        mCount = mCount + (mPush ? 1 : 0) - (mPop ? 1 : 0);
        if (mDropNow) begin
            mOvf  = 1'b1;
            mDrop = clr ? 16'd1 : ((mDrop == 16'hFFFF) ? mDrop : mDrop + 16'd1);
        end else if (clr) begin
            mOvf  = 1'b0;
            mDrop = '0;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.dadd_out_en   = 1'b0;
        bus.dadd_out_addr = '0;
        bus.dadd_out      = '0;
        bus.fwd_ready     = 1'b0;
        ovf_clr           = 1'b0;
        #3;
        checkOutput("rst_valid", 64'(bus.fwd_valid), 64'd0);
        checkOutput("rst_count", 64'(buf_count), 64'd0);
        checkOutput("rst_full", 64'(buf_full), 64'd0);
        checkOutput("rst_data", {bus.fwd_addr, bus.fwd_data}, 64'd0);
        checkOutput("rst_ovf", 64'(ovf_flag), 64'd0);
        #9 rst_n = 1'b1;

        // Basic transfer
        applyStimulus(1'b1, 32'd1, 32'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd2, 32'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("basic_popped", 64'(nPopped), 64'd2);

        // Fill, overflow, clear, full push+pop, drop coinciding with clear, drain
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i + 16), 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hAA, 32'hAA, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("ovf_set", 64'(ovf_flag), 64'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd9, 32'd9, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBB, 32'hBB, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("ovf_set_wins", 64'(ovf_flag), 64'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("fill_popped", 64'(nPopped), 64'd11);

        // Wrap with toggling ready
        nPopped = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus((i % 2) == 0, 32'(100 + i), 32'(i * 3), (i % 2) == 1, 1'b0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("wrap_popped", 64'(nPopped), 64'd20);

        // Random back-pressure stream
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(1)), $urandom, $urandom,
                          $urandom_range(3) != 0, $urandom_range(15) == 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Mid-stream reset with five beats buffered
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'(200 + i), 32'(50 + i), 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(bus.fwd_valid), 64'd0);
        checkOutput("mid_rst_count", 64'(buf_count), 64'd0);
        checkOutput("mid_rst_data", 64'(bus.fwd_data), 64'd0);
        #2 rst_n = 1'b1;
        expQ.delete();
        mCount = 0;
        mOvf   = 1'b0;
        mDrop  = '0;
        nPopped = 0;
        applyStimulus(1'b1, 32'h55, 32'h66, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("post_rst_popped", 64'(nPopped), 64'd1);
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
        $finish;
    end
endmodule
